dac_sample_pacer: RTL and testbench



---
 rtl/dac_sample_pacer.sv | 114 +++++++++++
 tb/tb_dac_sample_pacer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_pacer.sv
// rtl/dac_sample_pacer.sv - paced sample FIFO feeding the DAC code register at a programmable period
module dac_sample_pacer #(
    parameter int DEPTH = 8,
    parameter int DIV_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [DIV_W-1:0]         div,
    input  logic [9:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [9:0]               dac_d,
    output logic                     dac_strobe,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     underflow,
    input  logic                     clr_underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [9:0]       r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [DIV_W-1:0] r_cnt;
    logic [9:0]       r_dac;
    logic             r_strobe;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic             w_tick;
    logic             w_push;
    logic             w_pop;
    logic [LW-1:0]    w_level_nxt;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == FULL_LEVEL);
    assign w_tick  = enable && (r_cnt >= div);
    assign w_push  = in_valid && !w_full;
    // A tick on an empty FIFO never pops, even if a push lands in the same cycle.
    assign w_pop   = w_tick && !w_empty;

    assign in_ready   = !w_full;
    assign dac_d      = r_dac;
    assign dac_strobe = r_strobe;
    assign level      = r_level;
    assign underflow  = r_underflow;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LW'(1);
            2'b01:   w_level_nxt = r_level - LW'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_level <= w_level_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!enable) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dac       <= '0;
            r_strobe    <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_strobe <= w_pop;
            if (w_pop) begin
                r_dac <= r_mem[r_rd_ptr];
            end
            if (w_tick && w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_underflow) begin
                r_underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dac_sample_pacer.sv
// tb/tb_dac_sample_pacer.sv - randomized and directed checks of dac_sample_pacer against a queue model
module tb_dac_sample_pacer;

    localparam int DEPTH = 8;
    localparam int DIV_W = 16;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   enable;
    logic [DIV_W-1:0]       div;
    logic [9:0]             in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [9:0]             dac_d;
    logic                   dac_strobe;
    logic [$clog2(DEPTH):0] level;
    logic                   underflow;
    logic                   clr_underflow;

    always #5 clk = ~clk;

    dac_sample_pacer #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .div           (div),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .dac_d         (dac_d),
        .dac_strobe    (dac_strobe),
        .level         (level),
        .underflow     (underflow),
        .clr_underflow (clr_underflow)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int q[$];
    int m_dac;
    int m_cnt;
    bit m_strobe;
    bit m_uf;

    int st_val[$];
    int st_cyc[$];
    int max_level;
    int k;
    int s;
    int acc_cyc;
    int p_valid;
    bit acc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dac    = 0;
        m_cnt    = 0;
        m_strobe = 0;
        m_uf     = 0;
    endtask

    // Queue model: on a due tick the oldest sample goes to the DAC, else underflow.
    task automatic model_step();
        int  sz;
        bit  tick;
        bit  push;
        if (reset) begin
            model_reset();
            return;
        end
        sz       = q.size();
        push     = in_valid && (sz != DEPTH);
        tick     = enable && (m_cnt >= int'(div));
        m_strobe = 0;
        if (tick && sz > 0) begin
            m_dac    = q.pop_front();
            m_strobe = 1;
        end
        if (tick && sz == 0) m_uf = 1;
        else if (clr_underflow) m_uf = 0;
        if (push) q.push_back(int'(in_data));
        if (!enable || tick) m_cnt = 0;
        else m_cnt = m_cnt + 1;
    endtask

    task automatic compare();
        chk("dac_d", dac_d, m_dac);
        chk("dac_strobe", dac_strobe, m_strobe);
        chk("level", level, q.size());
        chk("underflow", underflow, m_uf);
        chk("in_ready", in_ready, q.size() != DEPTH);
        if (dac_strobe) begin
            st_val.push_back(int'(dac_d));
            st_cyc.push_back(cyc);
        end
        if (int'(level) > max_level) max_level = int'(level);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        compare();
    endtask

    task automatic clear_log();
        st_val.delete();
        st_cyc.delete();
        max_level = 0;
    endtask

    task automatic do_reset_mid();
        @(posedge clk);
        model_step();
        cyc++;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_async_level", level, 0);
        chk("rst_async_dac_d", dac_d, 0);
        chk("rst_async_strobe", dac_strobe, 0);
        chk("rst_async_underflow", underflow, 0);
        chk("rst_async_in_ready", in_ready, 1);
        compare();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; div = '0; in_data = '0; in_valid = 1'b0; clr_underflow = 1'b0;
        model_reset();
        clear_log();
        cycle();
        cycle();
        chk("reset_dac_d", dac_d, 0);
        chk("reset_level", level, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_underflow", underflow, 0);
        reset = 1'b0;
        cycle();

        // Three back-to-back samples paced every 4 cycles.
        clear_log();
        enable = 1'b1; div = 16'd3; in_valid = 1'b1;
        s = cyc;
        in_data = 10'd100; cycle();
        in_data = 10'd200; cycle();
        in_data = 10'd300; cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) cycle();
        enable = 1'b0;
        chk("t1_strobes", st_val.size(), 3);
        if (st_val.size() == 3) begin
            chk("t1_val0", st_val[0], 100);
            chk("t1_val1", st_val[1], 200);
            chk("t1_val2", st_val[2], 300);
            chk("t1_cyc0", st_cyc[0], s + 4);
            chk("t1_gap1", st_cyc[1] - st_cyc[0], 4);
            chk("t1_gap2", st_cyc[2] - st_cyc[1], 4);
        end
        chk("t1_max_level", max_level, 3);
        chk("t1_end_level", level, 0);
        cycle();

        // Underflow and clear priority on an empty FIFO.
        enable = 1'b1; div = 16'd1;
        cycle();
        cycle();
        chk("t2_uf_set", underflow, 1);
        chk("t2_dac_hold", dac_d, 300);
        clr_underflow = 1'b1;
        cycle();
        chk("t2_clr_nontick", underflow, 0);
        cycle();
        chk("t2_clr_on_tick", underflow, 1);
        enable = 1'b0;
        cycle();
        clr_underflow = 1'b0;

        // Fill to DEPTH with pacing off; the 9th waits for the first pop.
        k = 1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 10'(k);
            acc = in_ready;
            cycle();
            if (acc) k++;
        end
        chk("t3_full_level", level, 8);
        chk("t3_full_ready", in_ready, 0);
        chk("t3_accepted", k, 9);
        clear_log();
        enable = 1'b1; div = 16'd2;
        s = cyc; acc_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            acc = in_ready;
            cycle();
            if (acc && k == 9) begin
                acc_cyc = cyc;
                k = 10;
                in_valid = 1'b0;
            end
        end
        enable = 1'b0;
        chk("t3_strobes", st_val.size(), 9);
        if (st_val.size() == 9) begin
            chk("t3_first_tick", st_cyc[0], s + 3);
            chk("t3_ninth_accept", acc_cyc, st_cyc[0] + 1);
            for (int i = 0; i < 9; i++) chk("t3_order", st_val[i], i + 1);
        end
        clr_underflow = 1'b1;
        cycle();
        clr_underflow = 1'b0;

        // div=0 ramp through pointer wrap.
        in_valid = 1'b1; in_data = 10'd0;
        cycle();
        clear_log();
        enable = 1'b1; div = 16'd0;
        for (int v = 1; v < 16; v++) begin
            in_data = 10'(v);
            cycle();
            chk("t4_level", level, 1);
        end
        in_valid = 1'b0;
        cycle();
        enable = 1'b0;
        chk("t4_underflow", underflow, 0);
        chk("t4_strobes", st_val.size(), 16);
        if (st_val.size() == 16) begin
            for (int i = 0; i < 16; i++) chk("t4_order", st_val[i], i);
            chk("t4_span", st_cyc[15] - st_cyc[0], 15);
        end
        cycle();

        // Lower div below the running count.
        in_valid = 1'b1;
        for (int v = 50; v < 54; v++) begin
            in_data = 10'(v);
            cycle();
        end
        in_valid = 1'b0;
        clear_log();
        enable = 1'b1; div = 16'd10;
        for (int i = 0; i < 7; i++) cycle();
        chk("t5_no_early_tick", st_val.size(), 0);
        div = 16'd2;
        s = cyc;
        for (int i = 0; i < 7; i++) cycle();
        enable = 1'b0;
        chk("t5_strobes", st_cyc.size(), 3);
        if (st_cyc.size() == 3) begin
            chk("t5_first", st_cyc[0], s + 1);
            chk("t5_gap1", st_cyc[1] - st_cyc[0], 3);
            chk("t5_gap2", st_cyc[2] - st_cyc[1], 3);
        end

        // Mid-stream reset with five samples queued.
        in_valid = 1'b1;
        for (int v = 60; v < 64; v++) begin
            in_data = 10'(v);
            cycle();
        end
        in_valid = 1'b0;
        chk("t6_level5", level, 5);
        do_reset_mid();
        clear_log();
        enable = 1'b1; div = 16'd1; in_valid = 1'b1;
        for (int v = 70; v < 73; v++) begin
            in_data = 10'(v);
            cycle();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        enable = 1'b0;
        chk("t6_strobes", st_val.size(), 3);
        if (st_val.size() == 3) begin
            for (int i = 0; i < 3; i++) chk("t6_order", st_val[i], 70 + i);
        end

        // Randomized traffic, checked against the model every cycle.
        p_valid = 2;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) p_valid = int'($urandom_range(0, 3));
            if (i % 60 == 0) div = 16'($urandom_range(0, 5));
            enable        = ($urandom % 8) != 0;
            in_valid      = int'($urandom % 4) < p_valid;
            in_data       = 10'($urandom);
            clr_underflow = ($urandom % 16) == 0;
            if (i % 700 == 350) do_reset_mid();
            else cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
